// File: rtl/gumnut_exec_unit_if.sv
// Operand/result bus between the issue logic and the gumnut execute/writeback stage.
interface gumnut_exec_unit_if #(
   parameter int DW = 8,
   parameter int AW = 3
);
   logic          start;
   logic [3:0]    op_i;
   logic [AW-1:0] rd_i;
   logic [DW-1:0] a_i;
   logic [DW-1:0] b_i;
   logic [2:0]    cnt_i;
   logic          busy;
   logic          done;
   logic          we_o;
   logic [AW-1:0] rd_o;
   logic [DW-1:0] dat_o;
   logic          z_o;
   logic          c_o;

   modport master (
      output start, op_i, rd_i, a_i, b_i, cnt_i,
      input  busy, done, we_o, rd_o, dat_o, z_o, c_o
   );

   modport slave (
      input  start, op_i, rd_i, a_i, b_i, cnt_i,
      output busy, done, we_o, rd_o, dat_o, z_o, c_o
   );
endinterface

// File: rtl/gumnut_exec_unit.sv
// Gumnut execute/writeback stage: single-cycle ALU, serial shifter, Z/C flags.
// GUMNUT_EXEC_FAST_SHIFT_EN selects a one-cycle barrel shifter instead of the serial one.
module gumnut_exec_unit #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input logic               clkg,
   input logic               rst,
   gumnut_exec_unit_if.slave bus
);

`ifdef GUMNUT_EXEC_FAST_SHIFT_EN
   typedef enum logic [1:0] {IDLE, WB} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, WB} state_t;
`endif

   typedef enum logic [3:0] {
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_MASK,
      OP_SHL, OP_SHR, OP_ROL, OP_ROR
   } op_t;

   state_t        state, nxt;
   logic [DW-1:0] dat_q;
   logic [AW-1:0] rd_q;
   logic          z_q, c_q, legal_q;
   logic [DW:0]   alu;
   logic          is_shift;

   // One shift step: returns {out_bit, shifted value}; kind is op_i[1:0] of a shift op.
   function automatic logic [DW:0] step1(input logic [1:0] kind, input logic [DW-1:0] v);
      case (kind)
         2'd0:    step1 = {v[DW-1], v[DW-2:0], 1'b0};
         2'd1:    step1 = {v[0], 1'b0, v[DW-1:1]};
         2'd2:    step1 = {v[DW-1], v[DW-2:0], v[DW-1]};
         default: step1 = {v[0], v[0], v[DW-1:1]};
      endcase
   endfunction

   assign is_shift = (bus.op_i[3:2] == 2'b10);

   always_comb begin
      alu = '0;
      case (bus.op_i)
         OP_ADD:  alu = {1'b0, bus.a_i} + {1'b0, bus.b_i};
         OP_ADDC: alu = {1'b0, bus.a_i} + {1'b0, bus.b_i} + {{DW{1'b0}}, c_q};
         OP_SUB:  alu = {1'b0, bus.a_i} - {1'b0, bus.b_i};
         OP_SUBC: alu = {1'b0, bus.a_i} - {1'b0, bus.b_i} - {{DW{1'b0}}, c_q};
         OP_AND:  alu = {1'b0, bus.a_i & bus.b_i};
         OP_OR:   alu = {1'b0, bus.a_i | bus.b_i};
         OP_XOR:  alu = {1'b0, bus.a_i ^ bus.b_i};
         OP_MASK: alu = {1'b0, bus.a_i & ~bus.b_i};
         default: alu = '0;
      endcase
   end

`ifdef GUMNUT_EXEC_FAST_SHIFT_EN
   logic [DW:0] fr;

   // Unrolled repeat of the single step keeps carry semantics identical to the serial path.
   always_comb begin
      fr = {1'b0, bus.a_i};
      for (int unsigned i = 0; i < 7; i++) begin
         if (i < {29'd0, bus.cnt_i}) fr = step1(bus.op_i[1:0], fr[DW-1:0]);
      end
   end
`else
   logic [DW-1:0] sh_q;
   logic [2:0]    cnt_q;
   logic [1:0]    kind_q;
   logic [DW:0]   sstep;

   assign sstep = step1(kind_q, sh_q);
`endif

   always_ff @(posedge clkg or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
`ifdef GUMNUT_EXEC_FAST_SHIFT_EN
               nxt = WB;
`else
               nxt = (is_shift && bus.cnt_i != 3'd0) ? SHIFT : WB;
`endif
            end
         end
`ifndef GUMNUT_EXEC_FAST_SHIFT_EN
         SHIFT:   if (cnt_q == 3'd1) nxt = WB;
`endif
         WB:      nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clkg or posedge rst) begin
      if (rst) begin
         dat_q   <= '0;
         rd_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         legal_q <= 1'b0;
`ifndef GUMNUT_EXEC_FAST_SHIFT_EN
         sh_q    <= '0;
         cnt_q   <= '0;
         kind_q  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (!bus.op_i[3]) begin
                     dat_q   <= alu[DW-1:0];
                     c_q     <= alu[DW];
                     z_q     <= (alu[DW-1:0] == '0);
                     rd_q    <= bus.rd_i;
                     legal_q <= 1'b1;
                  end else if (is_shift) begin
                     rd_q    <= bus.rd_i;
                     legal_q <= 1'b1;
`ifdef GUMNUT_EXEC_FAST_SHIFT_EN
                     dat_q   <= fr[DW-1:0];
                     c_q     <= fr[DW];
                     z_q     <= (fr[DW-1:0] == '0);
`else
                     sh_q    <= bus.a_i;
                     cnt_q   <= bus.cnt_i;
                     kind_q  <= bus.op_i[1:0];
                     if (bus.cnt_i == 3'd0) begin
                        dat_q <= bus.a_i;
                        c_q   <= 1'b0;
                        z_q   <= (bus.a_i == '0);
                     end
`endif
                  end else begin
                     legal_q <= 1'b0;
                  end
               end
            end
`ifndef GUMNUT_EXEC_FAST_SHIFT_EN
            SHIFT: begin
               sh_q  <= sstep[DW-1:0];
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  dat_q <= sstep[DW-1:0];
                  c_q   <= sstep[DW];
                  z_q   <= (sstep[DW-1:0] == '0);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.busy  = (state != IDLE);
   assign bus.done  = (state == WB);
   assign bus.we_o  = (state == WB) && legal_q;
   assign bus.rd_o  = rd_q;
   assign bus.dat_o = dat_q;
   assign bus.z_o   = z_q;
   assign bus.c_o   = c_q;

endmodule
